spi_slave_frame_ctrl: RTL and testbench
=======================================

# spi_slave_frame_ctrl

Parametrised SPI slave frame controller. It is the next-generation front end between an external SPI master and the single-port RAM wrapper. It deserialises command/address/data frames of configurable width and serves read data back on MISO through a tx_valid/tx_ready handshake. Compared with the previous slave it adds bit-order selection, single-cycle rx_valid strobes, read-sequence enforcement, tx timeout and explicit error reporting.

## Interface
- WORD_W, 8: payload width (address/data word); frame width FRAME_W = WORD_W+2 (2 command bits + payload); legal range 4..32.
- LSB_FIRST, 0: 0 = MOSI/MISO bits MSB first; 1 = LSB first. Applies to both directions.
- TX_TIMEOUT, 64: maximum clk cycles spent waiting for tx_valid; legal range ≥2.
- clk  in  1  system clock; MOSI/SS_n are sampled on rising edge (synchronised upstream).
- rst_n  in  1  reset, synchronous, active-low.
- SS_n  in  1  slave select, active-low; frames a transaction.
- MOSI  in  1  serial data in.
- MISO  out  1  serial data out; 0 when not transmitting.
- rx_data  out  FRAME_W  last received frame {cmd[1:0], payload}; holds until next frame completes.
- rx_valid  out  1  one-cycle strobe: rx_data updated.
- tx_data  in  WORD_W  read data from RAM.
- tx_valid  in  1  tx_data valid; consumed only while tx_ready=1.
- tx_ready  out  1  high while in WAIT_TX.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle error strobe.
- err_code  out  2  cause of last err; 0 cmd mismatch, 1 abort, 2 read sequence, 3 tx timeout; holds until next err.

## Operation
- States: IDLE, CHK_CMD, RX, WAIT_TX, TX, DONE.
- IDLE: SS_n=0 -> CHK_CMD.
- CHK_CMD: MOSI sampled as rw bit (0 write, 1 read) -> RX; bit counter loaded with FRAME_W.
- RX: one bit per clk into shift register; on the edge sampling the last bit: rx_data <= assembled frame, then checks in order:
  - cmd[1] != rw: err, code 0; rx_valid stays 0; -> DONE.
  - cmd=2'b11 with rd_addr_ok=0: rx_valid=1; err, code 2; -> DONE.
  - cmd=2'b11 with rd_addr_ok=1: rx_valid=1 -> WAIT_TX.
  - otherwise: rx_valid=1 -> DONE; cmd=2'b10 sets rd_addr_ok.
- WAIT_TX: tx_ready=1. tx_valid=1 at an edge captures tx_data, drives the first bit on MISO -> TX. After TX_TIMEOUT cycles without tx_valid: err, code 3 -> DONE; rd_addr_ok cleared.
- TX: shifts remaining WORD_W-1 bits, one per clk. After the last bit has been driven one cycle: MISO=0, rd_addr_ok cleared -> DONE.
- DONE: ignores MOSI, MISO=0; SS_n=1 -> IDLE.
- SS_n=1 in CHK_CMD/RX/WAIT_TX/TX: -> IDLE next edge, err, code 1, MISO=0, partial frame discarded (rx_data unchanged), rd_addr_ok unchanged. SS_n=1 in CHK_CMD is an abort too.
- cmd 00 (write addr) and 01 (write data) do not affect rd_addr_ok.

## Timing
- Reset values: MISO=0, rx_data=0, rx_valid=0, tx_ready=0, busy=0, err=0, err_code=0. Internal: state=IDLE, rd_addr_ok=0, counters 0.
- Reset mid-frame has priority over everything; the next frame starts clean.
- Edge 0 sees SS_n=0 (IDLE->CHK_CMD). Edge 1 samples rw. Edges 2..FRAME_W+1 sample payload bits. rx_valid is high in the cycle after edge FRAME_W+1, for exactly one cycle.
- Bit order, LSB_FIRST=0: first payload bit -> rx_data[FRAME_W-1]. LSB_FIRST=1: first payload bit -> rx_data[0].
- tx capture edge: MISO shows bit 0 of the sequence during the following cycle. Each bit is held exactly one cycle. There are WORD_W consecutive MISO bits with no gap.
- tx_valid outside WAIT_TX is ignored. tx_valid on the same edge the timeout expires: the capture wins.
- SS_n is not sampled during IDLE->CHK_CMD beyond the start condition. Back-to-back frames need SS_n high for ≥1 edge.

## Test plan
- Write, WORD_W=8: rw=0, frame 00_1010_0101 -> rx_data=0x0A5, rx_valid one cycle after edge 11, err=0, busy drops one edge after SS_n rises.
- Read sequence: frame rw=1 10_0001_0000, then frame rw=1 11_xxxx_xxxx, tx_valid with tx_data=0xC3 after 3 cycles -> MISO=1,1,0,0,0,0,1,1 on consecutive cycles, then 0.
- Read data without a prior read-address frame -> rx_valid=1, err strobe, err_code=2, MISO stays 0, tx_ready never asserted.
- SS_n raised after 5 payload bits -> err, err_code=1, rx_data keeps its previous value, next full frame is received correctly.
- Timeout: valid read-data frame with tx_valid held low -> err, err_code=3 exactly TX_TIMEOUT cycles after entering WAIT_TX; tx_valid at the last cycle -> transmission instead.
- WORD_W=16, LSB_FIRST=1: read frame with tx_data=0x8001 -> MISO=1, fourteen 0s, 1. Also a rw=0 frame with cmd=2'b10 -> err_code=0, no rx_valid.

Source files
------------

// File: rtl/spi_slave_frame_ctrl_if.sv
// SPI slave frame controller bus: serial pins, rx frame, tx handshake, status.
// slave modport faces the controller, master modport faces the SPI/RAM side.
interface spi_slave_frame_ctrl_if #(
  parameter int WORD_W = 8
);
  localparam int FRAME_W = WORD_W + 2;

  logic               SS_n;
  logic               MOSI;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [WORD_W-1:0]  tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic               busy;
  logic               err;
  logic [1:0]         err_code;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, tx_ready,
    output busy, err, err_code
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, tx_ready,
    input  busy, err, err_code
  );
endinterface

// File: rtl/spi_slave_frame_ctrl.sv
// SPI slave frame controller: deserialises {cmd,payload} frames, serves reads.
// Ports: clk, rst_n (sync, active-low), bus (slave modport: SPI pins, rx/tx, status).
module spi_slave_frame_ctrl #(
  parameter int WORD_W     = 8,
  parameter bit LSB_FIRST  = 1'b0,
  parameter int TX_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_slave_frame_ctrl_if.slave bus
);
  localparam int FRAME_W = WORD_W + 2;
  localparam int CW      = $clog2(FRAME_W + 1);
  localparam int TW      = $clog2(TX_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, RX, WAIT_TX, TX, DONE
  } state_t;

  state_t             state;
  logic               rw;
  logic               rd_ok;
  logic [CW-1:0]      cnt;
  logic [TW-1:0]      tcnt;
  logic [FRAME_W-2:0] rx_sh;
  logic [WORD_W-1:0]  tx_sh;
  logic [FRAME_W-1:0] frame;
  logic [1:0]         cmd;
  logic               tx_first;
  logic               tx_bit;

  function automatic logic [WORD_W-1:0] tx_adv(
    input logic [WORD_W-1:0] v
  );
    return LSB_FIRST ? (v >> 1) : (v << 1);
  endfunction

  // frame as it stands once the bit on MOSI is included
  always_comb begin
    if (LSB_FIRST) frame = {bus.MOSI, rx_sh};
    else           frame = {rx_sh, bus.MOSI};
  end

  assign cmd      = frame[FRAME_W-1 -: 2];
  assign tx_first = LSB_FIRST ? bus.tx_data[0] : bus.tx_data[WORD_W-1];
  assign tx_bit   = LSB_FIRST ? tx_sh[0] : tx_sh[WORD_W-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rw           <= 1'b0;
      rd_ok        <= 1'b0;
      cnt          <= '0;
      tcnt         <= '0;
      rx_sh        <= '0;
      tx_sh        <= '0;
      bus.MISO     <= 1'b0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      bus.tx_ready <= 1'b0;
      bus.busy     <= 1'b0;
      bus.err      <= 1'b0;
      bus.err_code <= 2'd0;
    end else begin
      bus.rx_valid <= 1'b0;
      bus.err      <= 1'b0;
      if (bus.SS_n && (state == CHK_CMD || state == RX ||
                       state == WAIT_TX || state == TX)) begin
        // abort: partial frame dropped, rd_ok kept
        state        <= IDLE;
        bus.busy     <= 1'b0;
        bus.MISO     <= 1'b0;
        bus.tx_ready <= 1'b0;
        bus.err      <= 1'b1;
        bus.err_code <= 2'd1;
      end else begin
        unique case (state)
          IDLE: begin
            bus.MISO <= 1'b0;
            if (!bus.SS_n) begin
              state    <= CHK_CMD;
              bus.busy <= 1'b1;
            end
          end
          CHK_CMD: begin
            rw    <= bus.MOSI;
            cnt   <= CW'(FRAME_W);
            state <= RX;
          end
          RX: begin
            rx_sh <= LSB_FIRST ? frame[FRAME_W-1:1] : frame[FRAME_W-2:0];
            cnt   <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              bus.rx_data <= frame;
              if (cmd[1] != rw) begin
                bus.err      <= 1'b1;
                bus.err_code <= 2'd0;
                state        <= DONE;
              end else if (cmd == 2'b11) begin
                bus.rx_valid <= 1'b1;
                if (rd_ok) begin
                  bus.tx_ready <= 1'b1;
                  tcnt         <= '0;
                  state        <= WAIT_TX;
                end else begin
                  bus.err      <= 1'b1;
                  bus.err_code <= 2'd2;
                  state        <= DONE;
                end
              end else begin
                bus.rx_valid <= 1'b1;
                state        <= DONE;
                if (cmd == 2'b10) rd_ok <= 1'b1;
              end
            end
          end
          WAIT_TX: begin
            // a capture on the expiry edge beats the timeout
            if (bus.tx_valid) begin
              bus.tx_ready <= 1'b0;
              bus.MISO     <= tx_first;
              tx_sh        <= tx_adv(bus.tx_data);
              cnt          <= CW'(WORD_W - 1);
              state        <= TX;
            end else if (tcnt == TW'(TX_TIMEOUT - 1)) begin
              bus.tx_ready <= 1'b0;
              bus.err      <= 1'b1;
              bus.err_code <= 2'd3;
              rd_ok        <= 1'b0;
              state        <= DONE;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          TX: begin
            if (cnt != '0) begin
              bus.MISO <= tx_bit;
              tx_sh    <= tx_adv(tx_sh);
              cnt      <= cnt - CW'(1);
            end else begin
              bus.MISO <= 1'b0;
              rd_ok    <= 1'b0;
              state    <= DONE;
            end
          end
          DONE: begin
            bus.MISO <= 1'b0;
            if (bus.SS_n) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end
          default: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_frame_ctrl.sv
// Bench for spi_slave_frame_ctrl: 8-bit MSB-first and 16-bit LSB-first instances.
// Random frames are checked against a frame-level model of the read sequence.
module tb_spi_slave_frame_ctrl;
  localparam int T8 = 12;
  localparam int T16 = 64;

  logic clk;
  logic rst_n;
  int errors = 0;
  int checks = 0;
  bit rd_ok [2];

  logic o_miso, o_rxv, o_txr, o_busy, o_err;
  logic [1:0] o_code;
  logic [33:0] o_rx;

  spi_slave_frame_ctrl_if #(.WORD_W(8)) b8();
  spi_slave_frame_ctrl_if #(.WORD_W(16)) b16();

  spi_slave_frame_ctrl #(
    .WORD_W(8), .LSB_FIRST(1'b0), .TX_TIMEOUT(T8)
  ) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  spi_slave_frame_ctrl #(
    .WORD_W(16), .LSB_FIRST(1'b1), .TX_TIMEOUT(T16)
  ) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic int fw(input int s);
    return s == 0 ? 10 : 18;
  endfunction

  function automatic int ww(input int s);
    return s == 0 ? 8 : 16;
  endfunction

  task automatic sample(input int s);
    if (s == 0) begin
      o_miso = b8.MISO; o_rxv = b8.rx_valid; o_txr = b8.tx_ready;
      o_busy = b8.busy; o_err = b8.err; o_code = b8.err_code;
      o_rx = 34'(b8.rx_data);
    end else begin
      o_miso = b16.MISO; o_rxv = b16.rx_valid; o_txr = b16.tx_ready;
      o_busy = b16.busy; o_err = b16.err; o_code = b16.err_code;
      o_rx = 34'(b16.rx_data);
    end
  endtask

  // one clock: selected DUT gets the stimulus, the other stays deselected
  task automatic cyc(input int s, input logic ss, input logic mosi,
                     input logic txv, input logic [15:0] txd);
    b8.SS_n = (s == 0) ? ss : 1'b1;
    b8.MOSI = (s == 0) ? mosi : 1'b0;
    b8.tx_valid = (s == 0) ? txv : 1'b0;
    b8.tx_data = txd[7:0];
    b16.SS_n = (s == 1) ? ss : 1'b1;
    b16.MOSI = (s == 1) ? mosi : 1'b0;
    b16.tx_valid = (s == 1) ? txv : 1'b0;
    b16.tx_data = txd;
    @(posedge clk);
    #1;
    sample(s);
  endtask

  task automatic send(input int s, input logic rw, input logic [33:0] fr,
                      input int n);
    int f;
    logic b;
    f = fw(s);
    cyc(s, 1'b0, 1'($urandom), 1'b0, 16'($urandom));
    cyc(s, 1'b0, rw, 1'($urandom), 16'($urandom));
    for (int i = 0; i < n; i++) begin
      b = (s == 1) ? fr[i] : fr[f-1-i];
      cyc(s, 1'b0, b, 1'($urandom), 16'($urandom));
      if (i < f - 1) begin
        checks++;
        if (o_rxv !== 1'b0 || o_err !== 1'b0) begin
          errors++;
          $display("FAIL early_strobe s%0d bit%0d: got rxv=%b err=%b want 0 0",
                   s, i, o_rxv, o_err);
        end
      end
    end
  endtask

  task automatic expect_frame(input int s, input logic rw,
                              input logic [33:0] fr, output bit wait_tx);
    int f;
    logic [1:0] cmd;
    logic e_rxv, e_err;
    logic [1:0] e_code;
    f = fw(s);
    cmd = 2'((fr >> (f - 2)) & 34'd3);
    wait_tx = 1'b0;
    e_code = 2'd0;
    if (cmd[1] != rw) begin
      e_rxv = 1'b0; e_err = 1'b1; e_code = 2'd0;
    end else if (cmd == 2'b11 && !rd_ok[s]) begin
      e_rxv = 1'b1; e_err = 1'b1; e_code = 2'd2;
    end else begin
      e_rxv = 1'b1; e_err = 1'b0;
      wait_tx = (cmd == 2'b11);
      if (cmd == 2'b10) rd_ok[s] = 1'b1;
    end
    checks++;
    if (o_rx !== fr) begin
      errors++;
      $display("FAIL rx_data s%0d: got %h want %h", s, o_rx, fr);
    end
    checks++;
    if (o_rxv !== e_rxv) begin
      errors++;
      $display("FAIL rx_valid s%0d: got %b want %b", s, o_rxv, e_rxv);
    end
    checks++;
    if (o_err !== e_err) begin
      errors++;
      $display("FAIL err s%0d: got %b want %b", s, o_err, e_err);
    end
    if (e_err) begin
      checks++;
      if (o_code !== e_code) begin
        errors++;
        $display("FAIL err_code s%0d: got %0d want %0d", s, o_code, e_code);
      end
    end
    checks++;
    if (o_txr !== wait_tx || o_busy !== 1'b1 || o_miso !== 1'b0) begin
      errors++;
      $display("FAIL frame_status s%0d: got txr=%b busy=%b miso=%b want %b 1 0",
               s, o_txr, o_busy, o_miso, wait_tx);
    end
  endtask

  task automatic close(input int s);
    cyc(s, 1'b0, 1'($urandom), 1'($urandom), 16'($urandom));
    checks++;
    if (o_rxv !== 1'b0 || o_err !== 1'b0 || o_busy !== 1'b1 ||
        o_miso !== 1'b0 || o_txr !== 1'b0) begin
      errors++;
      $display("FAIL done_state s%0d: got rxv=%b err=%b busy=%b miso=%b txr=%b want 0 0 1 0 0",
               s, o_rxv, o_err, o_busy, o_miso, o_txr);
    end
    cyc(s, 1'b1, 1'b0, 1'b0, 16'd0);
    checks++;
    if (o_busy !== 1'b0 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL release s%0d: got busy=%b err=%b want 0 0", s, o_busy, o_err);
    end
  endtask

  task automatic do_tx(input int s, input int dly, input logic [15:0] d);
    int w;
    logic e;
    w = ww(s);
    for (int k = 0; k < dly; k++) begin
      cyc(s, 1'b0, 1'($urandom), 1'b0, 16'($urandom));
      checks++;
      if (o_txr !== 1'b1 || o_err !== 1'b0 || o_miso !== 1'b0) begin
        errors++;
        $display("FAIL wait_tx s%0d k%0d: got txr=%b err=%b miso=%b want 1 0 0",
                 s, k, o_txr, o_err, o_miso);
      end
    end
    cyc(s, 1'b0, 1'($urandom), 1'b1, d);
    for (int i = 0; i < w; i++) begin
      if (i > 0) cyc(s, 1'b0, 1'($urandom), 1'($urandom), 16'($urandom));
      e = (s == 1) ? d[i] : d[w-1-i];
      checks++;
      if (o_miso !== e || o_txr !== 1'b0 || o_err !== 1'b0) begin
        errors++;
        $display("FAIL miso_bit s%0d i%0d: got miso=%b txr=%b err=%b want %b 0 0",
                 s, i, o_miso, o_txr, o_err, e);
      end
    end
    cyc(s, 1'b0, 1'($urandom), 1'($urandom), 16'($urandom));
    checks++;
    if (o_miso !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL tx_end s%0d: got miso=%b busy=%b want 0 1", s, o_miso, o_busy);
    end
    rd_ok[s] = 1'b0;
    cyc(s, 1'b1, 1'b0, 1'b0, 16'd0);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL tx_release s%0d: got busy=%b want 0", s, o_busy);
    end
  endtask

  task automatic check_abort(input int s, input logic [33:0] prev);
    checks++;
    if (o_err !== 1'b1 || o_code !== 2'd1 || o_busy !== 1'b0 ||
        o_rx !== prev || o_rxv !== 1'b0 || o_miso !== 1'b0 || o_txr !== 1'b0) begin
      errors++;
      $display("FAIL abort s%0d: got err=%b code=%0d busy=%b rx=%h want 1 1 0 %h",
               s, o_err, o_code, o_busy, o_rx, prev);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sample(s);
      checks++;
      if (o_miso !== 1'b0 || o_rxv !== 1'b0 || o_txr !== 1'b0 ||
          o_busy !== 1'b0 || o_err !== 1'b0 || o_code !== 2'd0 ||
          o_rx !== 34'd0) begin
        errors++;
        $display("FAIL reset s%0d: got miso=%b rxv=%b txr=%b busy=%b err=%b code=%0d rx=%h want all 0",
                 s, o_miso, o_rxv, o_txr, o_busy, o_err, o_code, o_rx);
      end
    end
    rd_ok[0] = 1'b0;
    rd_ok[1] = 1'b0;
    rst_n = 1'b1;
    cyc(0, 1'b1, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic test_write();
    bit wt;
    logic [33:0] fr;
    send(0, 1'b0, 34'h0A5, 10);
    expect_frame(0, 1'b0, 34'h0A5, wt);
    close(0);
    for (int i = 0; i < 6; i++) begin
      fr = 34'({1'b0, 1'($urandom), 8'($urandom)});
      send(0, 1'b0, fr, 10);
      expect_frame(0, 1'b0, fr, wt);
      close(0);
    end
  endtask

  task automatic test_read_seq();
    bit wt;
    logic [33:0] fr;
    fr = 34'h210;
    send(0, 1'b1, fr, 10);
    expect_frame(0, 1'b1, fr, wt);
    close(0);
    fr = 34'({2'b11, 8'($urandom)});
    send(0, 1'b1, fr, 10);
    expect_frame(0, 1'b1, fr, wt);
    checks++;
    if (wt !== 1'b1) begin
      errors++;
      $display("FAIL read_seq_wait: got %b want 1", wt);
    end
    do_tx(0, 3, 16'h00C3);
  endtask

  task automatic test_read_no_addr();
    bit wt;
    logic [33:0] fr;
    fr = 34'({2'b11, 8'($urandom)});
    send(0, 1'b1, fr, 10);
    expect_frame(0, 1'b1, fr, wt);
    cyc(0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    checks++;
    if (o_miso !== 1'b0 || o_txr !== 1'b0 || o_code !== 2'd2) begin
      errors++;
      $display("FAIL no_addr_after: got miso=%b txr=%b code=%0d want 0 0 2",
               o_miso, o_txr, o_code);
    end
    close(0);
  endtask

  task automatic test_abort();
    bit wt;
    logic [33:0] f1, f2;
    f1 = 34'({2'b01, 8'($urandom)});
    send(0, 1'b0, f1, 10);
    expect_frame(0, 1'b0, f1, wt);
    close(0);
    send(0, 1'b0, 34'({2'b00, 8'($urandom)}), 5);
    cyc(0, 1'b1, 1'b0, 1'b0, 16'd0);
    check_abort(0, f1);
    cyc(0, 1'b1, 1'b0, 1'b0, 16'd0);
    checks++;
    if (o_err !== 1'b0 || o_code !== 2'd1) begin
      errors++;
      $display("FAIL abort_strobe: got err=%b code=%0d want 0 1", o_err, o_code);
    end
    f2 = 34'({2'b00, 8'($urandom)});
    send(0, 1'b0, f2, 10);
    expect_frame(0, 1'b0, f2, wt);
    close(0);
    cyc(0, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc(0, 1'b1, 1'b0, 1'b0, 16'd0);
    check_abort(0, f2);
    cyc(0, 1'b1, 1'b0, 1'b0, 16'd0);
    f1 = 34'({2'b10, 8'($urandom)});
    send(0, 1'b1, f1, 10);
    expect_frame(0, 1'b1, f1, wt);
    close(0);
    send(0, 1'b1, 34'h3FF, 5);
    cyc(0, 1'b1, 1'b0, 1'b0, 16'd0);
    check_abort(0, f1);
    cyc(0, 1'b1, 1'b0, 1'b0, 16'd0);
    f2 = 34'({2'b11, 8'($urandom)});
    send(0, 1'b1, f2, 10);
    expect_frame(0, 1'b1, f2, wt);
    cyc(0, 1'b1, 1'b0, 1'b1, 16'h00FF);
    check_abort(0, f2);
    cyc(0, 1'b1, 1'b0, 1'b0, 16'd0);
    send(0, 1'b1, f2, 10);
    expect_frame(0, 1'b1, f2, wt);
    do_tx(0, 1, 16'($urandom));
  endtask

  task automatic test_timeout();
    bit wt;
    logic [33:0] fr;
    fr = 34'({2'b10, 8'($urandom)});
    send(0, 1'b1, fr, 10);
    expect_frame(0, 1'b1, fr, wt);
    close(0);
    fr = 34'({2'b11, 8'($urandom)});
    send(0, 1'b1, fr, 10);
    expect_frame(0, 1'b1, fr, wt);
    for (int k = 1; k <= T8; k++) begin
      cyc(0, 1'b0, 1'($urandom), 1'b0, 16'($urandom));
      if (k < T8) begin
        checks++;
        if (o_err !== 1'b0 || o_txr !== 1'b1) begin
          errors++;
          $display("FAIL timeout_early k%0d: got err=%b txr=%b want 0 1", k, o_err, o_txr);
        end
      end else begin
        checks++;
        if (o_err !== 1'b1 || o_code !== 2'd3 || o_txr !== 1'b0 || o_miso !== 1'b0) begin
          errors++;
          $display("FAIL timeout: got err=%b code=%0d txr=%b want 1 3 0",
                   o_err, o_code, o_txr);
        end
      end
    end
    rd_ok[0] = 1'b0;
    close(0);
    send(0, 1'b1, fr, 10);
    expect_frame(0, 1'b1, fr, wt);
    close(0);
    fr = 34'({2'b10, 8'($urandom)});
    send(0, 1'b1, fr, 10);
    expect_frame(0, 1'b1, fr, wt);
    close(0);
    fr = 34'({2'b11, 8'($urandom)});
    send(0, 1'b1, fr, 10);
    expect_frame(0, 1'b1, fr, wt);
    do_tx(0, T8 - 1, 16'($urandom));
  endtask

  task automatic test_cmd_mismatch();
    bit wt;
    logic [33:0] fr;
    fr = 34'({2'b10, 8'($urandom)});
    send(0, 1'b0, fr, 10);
    expect_frame(0, 1'b0, fr, wt);
    close(0);
    fr = 34'({2'b01, 8'($urandom)});
    send(0, 1'b1, fr, 10);
    expect_frame(0, 1'b1, fr, wt);
    close(0);
  endtask

  task automatic test_w16();
    bit wt;
    logic [33:0] fr;
    fr = 34'({2'b10, 16'($urandom)});
    send(1, 1'b0, fr, 18);
    expect_frame(1, 1'b0, fr, wt);
    close(1);
    for (int i = 0; i < 3; i++) begin
      fr = 34'({2'b0, 1'($urandom), 16'($urandom)});
      send(1, 1'b0, fr, 18);
      expect_frame(1, 1'b0, fr, wt);
      close(1);
    end
    fr = 34'({2'b10, 16'($urandom)});
    send(1, 1'b1, fr, 18);
    expect_frame(1, 1'b1, fr, wt);
    close(1);
    fr = 34'({2'b11, 16'($urandom)});
    send(1, 1'b1, fr, 18);
    expect_frame(1, 1'b1, fr, wt);
    do_tx(1, 2, 16'h8001);
  endtask

  task automatic test_random();
    bit wt;
    int s;
    logic rw;
    logic [1:0] cmd;
    logic [33:0] fr;
    for (int i = 0; i < 30; i++) begin
      s = int'($urandom_range(0, 1));
      cmd = 2'($urandom);
      rw = ($urandom_range(0, 3) != 0) ? cmd[1] : ~cmd[1];
      if (s == 0) fr = 34'({cmd, 8'($urandom)});
      else fr = 34'({cmd, 16'($urandom)});
      send(s, rw, fr, fw(s));
      expect_frame(s, rw, fr, wt);
      if (wt) do_tx(s, int'($urandom_range(0, s == 0 ? T8 - 1 : 20)), 16'($urandom));
      else close(s);
    end
  endtask

  task automatic test_reset_mid();
    bit wt;
    logic [33:0] fr;
    fr = 34'({2'b10, 8'($urandom)});
    send(0, 1'b1, fr, 10);
    expect_frame(0, 1'b1, fr, wt);
    close(0);
    send(0, 1'b1, 34'h3AA, 4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sample(0);
    checks++;
    if (o_busy !== 1'b0 || o_rx !== 34'd0 || o_err !== 1'b0 ||
        o_miso !== 1'b0 || o_txr !== 1'b0 || o_code !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b rx=%h err=%b code=%0d want 0 0 0 0",
               o_busy, o_rx, o_err, o_code);
    end
    rd_ok[0] = 1'b0;
    rst_n = 1'b1;
    cyc(0, 1'b1, 1'b0, 1'b0, 16'd0);
    fr = 34'({2'b11, 8'($urandom)});
    send(0, 1'b1, fr, 10);
    expect_frame(0, 1'b1, fr, wt);
    close(0);
  endtask

  initial begin
    rst_n = 1'b0;
    b8.SS_n = 1'b1; b8.MOSI = 1'b0; b8.tx_valid = 1'b0; b8.tx_data = '0;
    b16.SS_n = 1'b1; b16.MOSI = 1'b0; b16.tx_valid = 1'b0; b16.tx_data = '0;
    test_reset();
    test_write();
    test_read_seq();
    test_read_no_addr();
    test_abort();
    test_timeout();
    test_cmd_mismatch();
    test_w16();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
